uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 8, SHALL set FIFO entries; legal values are powers of 2 from 2 to 64.
REQ-003 Port Clk, input, 1 bit, SHALL be the system clock; all state updates on its rising edge.
REQ-004 Port Rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-005 Port Wr_Data, input, 8 bits, SHALL carry the byte offered for transmission.
REQ-006 Port Wr_Valid, input, 1 bit, SHALL indicate that Wr_Data is valid.
REQ-007 Port Wr_Ready, output, 1 bit, SHALL be high when the FIFO can accept a byte (Count < DEPTH).
REQ-008 Port Tx_Data, output, 8 bits, SHALL be the byte presented to the downstream UART transmitter.
REQ-009 Port Tx_Start, output, 1 bit, SHALL be a single-cycle request for the transmitter to send Tx_Data.
REQ-010 Port Tx_EOT, input, 1 bit, SHALL be the transmitter status: high = idle/frame done, low = frame in progress.
REQ-011 Port Count, output, $clog2(DEPTH)+1 bits, SHALL report the number of stored bytes.
REQ-012 Port Busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE or Count > 0.

Function
REQ-013 A push SHALL occur on a cycle with Wr_Valid=1 and Wr_Ready=1; Wr_Ready SHALL be combinational from Count.
REQ-014 The FIFO SHALL be circular: write and read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-015 Bytes SHALL leave in push order; none SHALL be dropped or duplicated.
REQ-016 The FSM SHALL have four states: IDLE, START, WAIT_LOW, WAIT_HIGH.
REQ-017 IDLE -> START SHALL occur when Count > 0 and Tx_EOT=1; on that edge the head byte is popped into the Tx_Data register.
REQ-018 In START, Tx_Start SHALL be 1 for exactly one cycle; the next state SHALL be WAIT_LOW.
REQ-019 WAIT_LOW SHALL hold until Tx_EOT=0, then go to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL hold until Tx_EOT=1, then go to IDLE.
REQ-021 Tx_Data SHALL stay stable from the START cycle until the FSM re-enters IDLE.
REQ-022 Back-to-back frames: with Count > 0 on IDLE re-entry, START SHALL follow one cycle later, giving a 2-cycle gap from Tx_EOT rise to the next Tx_Start.
REQ-023 A simultaneous push and pop SHALL leave Count unchanged and both pointers advanced.
REQ-024 A push to the full FIFO SHALL not occur, because Wr_Ready=0; Wr_Valid while full SHALL have no effect.
REQ-025 A push into an empty FIFO SHALL make Count=1 on the next cycle; the earliest Tx_Start SHALL follow 2 cycles after the push edge.
REQ-026 Tx_EOT=0 while in IDLE SHALL block the transition to START.

Reset
REQ-027 Rst=1 on a rising edge SHALL set FSM=IDLE, both pointers=0, Count=0, Tx_Data=8'h00 and Tx_Start=0; consequently Wr_Ready=1 and Busy=0.
REQ-028 Reset mid-frame SHALL discard all stored bytes and the in-flight byte with no further Tx_Start; FIFO memory contents need not be cleared.
REQ-029 Pushes while Rst=1 SHALL be ignored.

Verification
REQ-030 Single byte: push 8'hAA into the empty FIFO with a model transmitter (EOT low for 100 cycles) -> one Tx_Start pulse, Tx_Data=8'hAA stable until EOT rises, then Count=0 and Busy=0.
REQ-031 Burst order: push 8'hAA, 8'h03, 8'hCC on consecutive cycles -> Tx_Start pulses with Tx_Data 8'hAA, 8'h03, 8'hCC in that order, each 2 cycles after the previous EOT rise.
REQ-032 Full: push DEPTH=8 bytes 8'h00..8'h07 while Tx_EOT is held low -> Count=8 and Wr_Ready=0; a ninth Wr_Valid with 8'hFF is ignored, and after EOT is released, exactly 8 bytes 00..07 go out.
REQ-033 Simultaneous push and pop: Count=3 with a push on the IDLE->START edge -> Count stays 3, and the pushed byte is sent fourth.
REQ-034 Wrap-around: stream 20 sequential bytes through DEPTH=8 -> all 20 bytes are received in order.
REQ-035 Reset mid-frame: assert Rst in WAIT_LOW with Count=4 -> next cycle Count=0, Tx_Start=0, Tx_Data=8'h00, Wr_Ready=1, and no further Tx_Start.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter: buffers pushed bytes and hands them out one
// frame at a time, pacing on the transmitter's end-of-transmission status.
module uart_tx_buffer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [7:0]                 Wr_Data,
    input  logic                       Wr_Valid,
    output logic                       Wr_Ready,
    output logic [7:0]                 Tx_Data,
    output logic                       Tx_Start,
    input  logic                       Tx_EOT,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitLow,
        StWaitHigh
    } state_e;

    state_e          state_q;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;

    assign Wr_Ready = (count_q < DepthC);
    assign push     = Wr_Valid && Wr_Ready;
    // A pop is the IDLE->START launch of the head byte.
    assign pop      = (state_q == StIdle) && (count_q != '0) && Tx_EOT;

    assign Count = count_q;
    assign Busy  = (state_q != StIdle) || (count_q != '0);

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge Clk) begin
        if (push && !Rst) begin
            mem_q[wr_ptr_q] <= Wr_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= StIdle;
            Tx_Data  <= 8'h00;
            Tx_Start <= 1'b0;
        end else begin
            Tx_Start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        Tx_Data  <= mem_q[rd_ptr_q];
                        Tx_Start <= 1'b1;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    state_q <= StWaitLow;
                end
                // Wait for the transmitter to acknowledge by dropping EOT, then for frame end.
                StWaitLow: begin
                    if (!Tx_EOT) begin
                        state_q <= StWaitHigh;
                    end
                end
                StWaitHigh: begin
                    if (Tx_EOT) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a model transmitter, a byte scoreboard,
// a table of push/hold vectors and hand-written multi-cycle sequences.
module tb_uart_tx_buffer;

    localparam int DEPTH = 8;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] Wr_Data;
    logic       Wr_Valid;
    logic       Wr_Ready;
    logic [7:0] Tx_Data;
    logic       Tx_Start;
    logic       Tx_EOT;
    logic [3:0] Count;
    logic       Busy;

    always #5 Clk = ~Clk;

    uart_tx_buffer #(.DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Wr_Data  (Wr_Data),
        .Wr_Valid (Wr_Valid),
        .Wr_Ready (Wr_Ready),
        .Tx_Data  (Tx_Data),
        .Tx_Start (Tx_Start),
        .Tx_EOT   (Tx_EOT),
        .Count    (Count),
        .Busy     (Busy)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Model transmitter: EOT drops for tx_len cycles after each Tx_Start; tx_hold forces it low.
    logic tx_hold = 1'b0;
    int   tx_len  = 4;
    int   tx_cnt  = 0;
    int   cyc     = 0;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Rst)                tx_cnt <= 0;
        else if (Tx_Start)      tx_cnt <= tx_len;
        else if (tx_cnt != 0)   tx_cnt <= tx_cnt - 1;
    end

    assign Tx_EOT = !tx_hold && (tx_cnt == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Output monitor: scoreboard pop on Tx_Start, data stability, back-to-back gap.
    logic [7:0] cur       = 8'h00;
    logic       in_frame  = 1'b0;
    logic       seen_low  = 1'b0;
    logic       prev_eot  = 1'b1;
    logic       have_rise = 1'b0;
    logic       gap_chk   = 1'b0;
    int         rise_cyc  = 0;
    int         start_cyc = -1;

    always @(negedge Clk) begin
        if (in_frame) begin
            check("tx_data_stable", 32'(Tx_Data), 32'(cur));
            if (!Tx_EOT)       seen_low = 1'b1;
            else if (seen_low) in_frame = 1'b0;
        end
        if (Tx_EOT && !prev_eot) begin
            rise_cyc  = cyc;
            have_rise = 1'b1;
        end
        prev_eot = Tx_EOT;
        if (Tx_Start) begin
            start_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_start_unexpected: Tx_Data 0x%0h with no byte pending at cycle %0d",
                         Tx_Data, cyc);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (Tx_Data !== e) begin
                    errors++;
                    $display("FAIL tx_data_order: got 0x%0h expected 0x%0h at cycle %0d",
                             Tx_Data, e, cyc);
                end
            end
            if (gap_chk && have_rise) check("b2b_gap", 32'(cyc - rise_cyc), 32'd2);
            have_rise = 1'b0;
            cur       = Tx_Data;
            in_frame  = 1'b1;
            seen_low  = 1'b0;
        end
    end

    // Called at a negedge; waits (bounded) for space, then pushes for one cycle.
    task automatic push(input logic [7:0] d);
        int n = 0;
        while (!Wr_Ready && n < 500) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: Wr_Ready low for %0d cycles, Count=%0d", n, Count);
        end
        Wr_Valid = 1'b1;
        Wr_Data  = d;
        exp_q.push_back(d);
        @(negedge Clk);
        Wr_Valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || Busy) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes pending, Busy=%0b", exp_q.size(), Busy);
        end
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        int         exp_count;
        logic       exp_ready;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int model_cnt;
        int push_cyc;
        int n;

        // Transmitter held busy: bytes pile up, the ninth is refused.
        vecs[0] = '{1'b0, 8'h00, 0, 1'b1, 1'b0};
        for (int i = 1; i <= 8; i++) begin
            vecs[i] = '{1'b1, 8'(i - 1), i, (i < DEPTH), 1'b1};
        end
        vecs[9]  = '{1'b1, 8'hFF, 8, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 8, 1'b0, 1'b1};

        // Reset, with a push attempted while Rst is high.
        Rst = 1'b1; Wr_Valid = 1'b0; Wr_Data = 8'h00;
        repeat (2) @(negedge Clk);
        Wr_Valid = 1'b1; Wr_Data = 8'h55;
        @(negedge Clk);
        Wr_Valid = 1'b0; Rst = 1'b0;
        check("reset_count", 32'(Count), 32'd0);
        check("reset_wr_ready", 32'(Wr_Ready), 32'd1);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_tx_start", 32'(Tx_Start), 32'd0);
        check("reset_tx_data", 32'(Tx_Data), 32'h00);
        repeat (3) @(negedge Clk);
        check("reset_push_ignored", 32'(Count), 32'd0);

        // Single byte, long frame; first Tx_Start two cycles after the push cycle.
        tx_len = 100;
        push_cyc = cyc;
        push(8'hAA);
        drain(400);
        check("push_to_start_latency", 32'(start_cyc - push_cyc), 32'd2);
        check("single_count", 32'(Count), 32'd0);
        check("single_busy", 32'(Busy), 32'd0);

        // Burst of three back-to-back frames.
        tx_len = 5;
        have_rise = 1'b0;
        gap_chk = 1'b1;
        push(8'hAA);
        push(8'h03);
        push(8'hCC);
        drain(400);
        gap_chk = 1'b0;

        // Table: fill to full while EOT is held low.
        tx_hold = 1'b1;
        model_cnt = 0;
        foreach (vecs[i]) begin
            Wr_Valid = vecs[i].valid;
            Wr_Data  = vecs[i].data;
            if (vecs[i].valid && model_cnt < DEPTH) exp_q.push_back(vecs[i].data);
            @(negedge Clk);
            Wr_Valid = 1'b0;
            check($sformatf("vec%0d_count", i), 32'(Count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_wr_ready", i), 32'(Wr_Ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_busy", i), 32'(Busy), 32'(vecs[i].exp_busy));
            model_cnt = vecs[i].exp_count;
        end
        tx_hold = 1'b0;
        tx_len = 3;
        drain(800);
        check("full_drained_count", 32'(Count), 32'd0);

        // Push on the same edge as the IDLE->START pop.
        tx_hold = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("pp_pre_count", 32'(Count), 32'd3);
        tx_hold = 1'b0;
        Wr_Valid = 1'b1;
        Wr_Data = 8'h44;
        exp_q.push_back(8'h44);
        @(negedge Clk);
        Wr_Valid = 1'b0;
        check("pp_count_unchanged", 32'(Count), 32'd3);
        check("pp_tx_start", 32'(Tx_Start), 32'd1);
        drain(400);

        // Stream 20 bytes so both pointers wrap.
        tx_len = 2;
        for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
        drain(2000);
        check("wrap_count", 32'(Count), 32'd0);

        // Reset in WAIT_LOW with four bytes still queued.
        tx_hold = 1'b1;
        tx_len = 20;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        tx_hold = 1'b0;
        n = 0;
        while (!Tx_Start && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("rst_mid_start_seen", 32'(Tx_Start), 32'd1);
        @(negedge Clk);
        check("rst_mid_pre_count", 32'(Count), 32'd4);
        Rst = 1'b1;
        exp_q.delete();
        in_frame = 1'b0;
        @(negedge Clk);
        check("rst_mid_count", 32'(Count), 32'd0);
        check("rst_mid_tx_start", 32'(Tx_Start), 32'd0);
        check("rst_mid_tx_data", 32'(Tx_Data), 32'h00);
        check("rst_mid_wr_ready", 32'(Wr_Ready), 32'd1);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        Rst = 1'b0;
        repeat (150) @(negedge Clk);
        check("rst_mid_after_count", 32'(Count), 32'd0);
        check("rst_mid_after_busy", 32'(Busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
